// File: rtl/mem_pkg.sv
// Shared types, constants and helpers for the M-stage memory access unit
// and the W-stage load extension.
package mem_pkg;

    typedef enum logic [2:0] {
        MEM_WORD   = 3'd0,
        MEM_HALF_U = 3'd1,
        MEM_HALF_S = 3'd2,
        MEM_BYTE_U = 3'd3,
        MEM_BYTE_S = 3'd4
    } memType_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP,
        ST_EXC
    } memState_e;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam logic [31:0] RESET_ADDR_DEFAULT = 32'h0000_3000;

    function automatic logic isHalf(input logic [2:0] memType);
        return (memType == MEM_HALF_U) || (memType == MEM_HALF_S);
    endfunction

    function automatic logic isByte(input logic [2:0] memType);
        return (memType == MEM_BYTE_U) || (memType == MEM_BYTE_S);
    endfunction

    // Unknown type codes are treated like words so they can never slip through unaligned.
    function automatic logic isMisaligned(input logic [2:0] memType, input logic [1:0] addrLow);
        logic result;
        if (isByte(memType)) begin
            result = 1'b0;
        end else if (isHalf(memType)) begin
            result = addrLow[0];
        end else begin
            result = (addrLow != 2'b00);
        end
        return result;
    endfunction

    function automatic logic [3:0] byteEnable(input logic [2:0] memType, input logic [1:0] addrLow);
        logic [3:0] result;
        if (isByte(memType)) begin
            result = 4'b0001 << addrLow;
        end else if (isHalf(memType)) begin
            result = addrLow[1] ? 4'b1100 : 4'b0011;
        end else begin
            result = 4'b1111;
        end
        return result;
    endfunction

    function automatic logic [31:0] laneData(input logic [2:0] memType, input logic [31:0] wdata);
        logic [31:0] result;
        if (isByte(memType)) begin
            result = {4{wdata[7:0]}};
        end else if (isHalf(memType)) begin
            result = {2{wdata[15:0]}};
        end else begin
            result = wdata;
        end
        return result;
    endfunction

endpackage

// File: rtl/m_mem_access_if.sv
// Pipeline-side request/response signals plus the word-wide req/ack data bus
// of the memory access stage; master is the access unit, slave its environment.
interface m_mem_access_if;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_valid;
    logic [4:0]  exc_code;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        input  req_valid, req_we, req_type, req_addr, req_wdata, flush,
        input  bus_ack, bus_rdata,
        output stall, resp_valid, resp_rdata, exc_valid, exc_code,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output req_valid, req_we, req_type, req_addr, req_wdata, flush,
        output bus_ack, bus_rdata,
        input  stall, resp_valid, resp_rdata, exc_valid, exc_code,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );

endinterface

// File: rtl/mem_load_ext.sv
// Selects the addressed byte/half lane of a bus word and sign- or zero-extends it;
// shared by the M-stage access unit and the W-stage bypass.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [1:0]  addrLow,
    input  logic [2:0]  memType,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane = word[{addrLow, 3'b000} +: 8];
        halfLane = addrLow[1] ? word[31:16] : word[15:0];
        result   = word;
        case (memType)
            MEM_HALF_U: result = {16'h0000, halfLane};
            MEM_HALF_S: result = {{16{halfLane[15]}}, halfLane};
            MEM_BYTE_U: result = {24'h00_0000, byteLane};
            MEM_BYTE_S: result = {{24{byteLane[7]}}, byteLane};
            default:    result = word;
        endcase
    end

endmodule

// File: rtl/m_mem_access.sv
// Memory-access stage: one load/store per M instruction over a req/ack bus, with
// pipeline stall, load extension and AdEL/AdES (and, with MEM_TIMEOUT_EN, DBE) exceptions.
module m_mem_access
    import mem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] RESET_ADDR     = RESET_ADDR_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    m_mem_access_if.master bus
);

    memState_e   state;
    memState_e   stateNext;
    logic        accept;
    logic        misaligned;
    logic        timeoutHit;

    logic [31:0] addrReg;
    logic [1:0]  addrLowReg;
    logic [2:0]  typeReg;
    logic        weReg;
    logic [3:0]  beReg;
    logic [31:0] wdataReg;
    logic [31:0] rdataReg;
    logic [4:0]  excReg;
    logic        flushed;
    logic [31:0] loadWord;

    assign accept     = bus.req_valid && !bus.flush;
    assign misaligned = isMisaligned(bus.req_type, bus.req_addr[1:0]);

    mem_load_ext loadExt (
        .addrLow (addrLowReg),
        .memType (typeReg),
        .word    (bus.bus_rdata),
        .result  (loadWord)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] waitCnt;

    // Held at zero outside BUS, so every transaction starts counting from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (state != ST_BUS) begin
            waitCnt <= '0;
        end else if (!bus.bus_ack) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    assign timeoutHit = (state == ST_BUS) && !bus.bus_ack &&
                        (waitCnt == CntW'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the budget is irrelevant and a BUS wait never ends early.
    assign timeoutHit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // A flushed transaction still has to finish on the bus; only its result is dropped.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    stateNext = misaligned ? ST_EXC : ST_BUS;
                end
            end
            ST_BUS: begin
                if (timeoutHit) begin
                    stateNext = ST_EXC;
                end else if (bus.bus_ack) begin
                    stateNext = (flushed || bus.flush) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            ST_EXC:  stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrReg    <= '0;
            addrLowReg <= '0;
            typeReg    <= '0;
            weReg      <= 1'b0;
            beReg      <= '0;
            wdataReg   <= '0;
            rdataReg   <= '0;
            excReg     <= '0;
            flushed    <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && accept) begin
                if (misaligned) begin
                    excReg <= bus.req_we ? EXC_ADES : EXC_ADEL;
                end else begin
                    addrReg    <= {bus.req_addr[31:2], 2'b00};
                    addrLowReg <= bus.req_addr[1:0];
                    typeReg    <= bus.req_type;
                    weReg      <= bus.req_we;
                    beReg      <= byteEnable(bus.req_type, bus.req_addr[1:0]);
                    wdataReg   <= laneData(bus.req_type, bus.req_wdata);
                    flushed    <= 1'b0;
                end
            end
            if (state == ST_BUS) begin
                if (bus.flush) begin
                    flushed <= 1'b1;
                end
                if (timeoutHit) begin
                    excReg <= EXC_DBE;
                end else if (bus.bus_ack) begin
                    rdataReg <= weReg ? 32'h0000_0000 : loadWord;
                end
            end
        end
    end

    // The IDLE stall is gated by reset so every output reads zero while reset is held.
    always_comb begin
        bus.stall      = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.exc_valid  = 1'b0;
        bus.exc_code   = '0;
        bus.bus_req    = 1'b0;
        bus.bus_we     = 1'b0;
        bus.bus_addr   = RESET_ADDR;
        bus.bus_be     = '0;
        bus.bus_wdata  = '0;
        case (state)
            ST_IDLE: begin
                bus.stall = reset && accept && !misaligned;
            end
            ST_BUS: begin
                bus.stall     = 1'b1;
                bus.bus_req   = 1'b1;
                bus.bus_we    = weReg;
                bus.bus_addr  = addrReg;
                bus.bus_be    = beReg;
                bus.bus_wdata = wdataReg;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = rdataReg;
            end
            ST_EXC: begin
                bus.exc_valid = 1'b1;
                bus.exc_code  = excReg;
            end
            default: begin
                bus.stall = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_m_mem_access.sv
// Directed bench for m_mem_access; the timeout scenario follows MEM_TIMEOUT_EN.
module tb_m_mem_access;
    import mem_pkg::*;

    localparam logic [31:0] RstAddr = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    m_mem_access_if busIf();

    m_mem_access #(
        .TIMEOUT_CYCLES (4),
        .RESET_ADDR     (RstAddr)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busIf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        busIf.req_valid = 1'b0;
        busIf.req_we    = 1'b0;
        busIf.req_type  = 3'd0;
        busIf.req_addr  = 32'h0;
        busIf.req_wdata = 32'h0;
        busIf.flush     = 1'b0;
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [2:0] memType,
                         input logic [31:0] addr, input logic [31:0] wdata);
        busIf.req_valid = 1'b1;
        busIf.req_we    = we;
        busIf.req_type  = memType;
        busIf.req_addr  = addr;
        busIf.req_wdata = wdata;
    endtask

    task automatic test_reset();
        idleInputs();
        reset = 1'b0;
        #2;
        checks++;
        if ({busIf.bus_req, busIf.stall, busIf.resp_valid, busIf.exc_valid, busIf.bus_we} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {busIf.bus_req, busIf.stall, busIf.resp_valid, busIf.exc_valid, busIf.bus_we});
        end
        checks++;
        if (busIf.bus_addr !== RstAddr) begin
            failures++;
            $display("[TB] FAIL reset_bus_addr: got %h expected %h", busIf.bus_addr, RstAddr);
        end
        checks++;
        if ({busIf.resp_rdata, busIf.exc_code, busIf.bus_be, busIf.bus_wdata} !== 73'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: got %h expected 0",
                     {busIf.resp_rdata, busIf.exc_code, busIf.bus_be, busIf.bus_wdata});
        end
        drive(1'b0, MEM_WORD, 32'h0000_0004, 32'h0);
        #1;
        checks++;
        if (busIf.stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall_gated: got %b expected 0", busIf.stall);
        end
        idleInputs();
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        nextCycle();
    endtask

    task automatic test_word_load();
        drive(1'b0, MEM_WORD, 32'h0000_0004, 32'h0);
        #1;
        checks++;
        if ({busIf.stall, busIf.bus_req} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL word_accept: got %b expected 10", {busIf.stall, busIf.bus_req});
        end
        nextCycle();
        busIf.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                busIf.bus_ack   = 1'b1;
                busIf.bus_rdata = 32'hDEAD_BEEF;
            end
            #1;
            checks++;
            if ({busIf.stall, busIf.bus_req, busIf.resp_valid} !== 3'b110) begin
                failures++;
                $display("[TB] FAIL word_bus_cycle%0d: got %b expected 110", i,
                         {busIf.stall, busIf.bus_req, busIf.resp_valid});
            end
            checks++;
            if ({busIf.bus_be, busIf.bus_addr, busIf.bus_we} !== {4'b1111, 32'h0000_0004, 1'b0}) begin
                failures++;
                $display("[TB] FAIL word_bus_fields%0d: got be=%b addr=%h we=%b expected be=1111 addr=00000004 we=0",
                         i, busIf.bus_be, busIf.bus_addr, busIf.bus_we);
            end
            nextCycle();
        end
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.stall, busIf.bus_req} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL word_resp: got %b expected 100",
                     {busIf.resp_valid, busIf.stall, busIf.bus_req});
        end
        checks++;
        if (busIf.resp_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("[TB] FAIL word_rdata: got %h expected deadbeef", busIf.resp_rdata);
        end
        nextCycle();
        #1;
        checks++;
        if (busIf.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL word_resp_once: got %b expected 0", busIf.resp_valid);
        end
        nextCycle();
    endtask

    task automatic test_byte_signed_load();
        drive(1'b0, MEM_BYTE_S, 32'h0000_0003, 32'h0);
        nextCycle();
        busIf.req_valid = 1'b0;
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h80FF_1234;
        #1;
        checks++;
        if ({busIf.bus_req, busIf.bus_be, busIf.bus_addr} !== {1'b1, 4'b1000, 32'h0}) begin
            failures++;
            $display("[TB] FAIL byte_bus: got req=%b be=%b addr=%h expected req=1 be=1000 addr=00000000",
                     busIf.bus_req, busIf.bus_be, busIf.bus_addr);
        end
        nextCycle();
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.resp_rdata} !== {1'b1, 32'hFFFF_FF80}) begin
            failures++;
            $display("[TB] FAIL byte_resp: got valid=%b rdata=%h expected valid=1 rdata=ffffff80",
                     busIf.resp_valid, busIf.resp_rdata);
        end
        nextCycle();
    endtask

    task automatic test_half_store();
        drive(1'b1, MEM_HALF_U, 32'h0000_0006, 32'h0000_ABCD);
        nextCycle();
        busIf.req_valid = 1'b0;
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({busIf.bus_we, busIf.bus_be, busIf.bus_addr} !== {1'b1, 4'b1100, 32'h0000_0004}) begin
            failures++;
            $display("[TB] FAIL half_store_bus: got we=%b be=%b addr=%h expected we=1 be=1100 addr=00000004",
                     busIf.bus_we, busIf.bus_be, busIf.bus_addr);
        end
        checks++;
        if (busIf.bus_wdata !== 32'hABCD_ABCD) begin
            failures++;
            $display("[TB] FAIL half_store_wdata: got %h expected abcdabcd", busIf.bus_wdata);
        end
        nextCycle();
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.resp_rdata} !== {1'b1, 32'h0}) begin
            failures++;
            $display("[TB] FAIL half_store_resp: got valid=%b rdata=%h expected valid=1 rdata=00000000",
                     busIf.resp_valid, busIf.resp_rdata);
        end
        nextCycle();
    endtask

    task automatic test_misaligned();
        logic [2:0]  types [2]  = '{MEM_WORD, MEM_HALF_U};
        logic [31:0] addrs [2]  = '{32'h0000_0002, 32'h0000_0001};
        logic        wes   [2]  = '{1'b0, 1'b1};
        logic [4:0]  codes [2]  = '{5'd4, 5'd5};
        for (int i = 0; i < 2; i++) begin
            drive(wes[i], types[i], addrs[i], 32'h5555_5555);
            #1;
            checks++;
            if ({busIf.stall, busIf.bus_req} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL misalign%0d_accept: got %b expected 00", i,
                         {busIf.stall, busIf.bus_req});
            end
            nextCycle();
            busIf.req_valid = 1'b0;
            #1;
            checks++;
            if ({busIf.exc_valid, busIf.bus_req, busIf.stall, busIf.exc_code} !== {3'b100, codes[i]}) begin
                failures++;
                $display("[TB] FAIL misalign%0d_exc: got valid=%b req=%b stall=%b code=%0d expected 1 0 0 %0d",
                         i, busIf.exc_valid, busIf.bus_req, busIf.stall, busIf.exc_code, codes[i]);
            end
            nextCycle();
            #1;
            checks++;
            if ({busIf.exc_valid, busIf.bus_req} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL misalign%0d_after: got %b expected 00", i,
                         {busIf.exc_valid, busIf.bus_req});
            end
            nextCycle();
        end
    endtask

    task automatic test_flush();
        drive(1'b0, MEM_WORD, 32'h0000_0040, 32'h0);
        busIf.flush = 1'b1;
        #1;
        checks++;
        if (busIf.stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_idle_stall: got %b expected 0", busIf.stall);
        end
        nextCycle();
        idleInputs();
        #1;
        checks++;
        if ({busIf.bus_req, busIf.exc_valid, busIf.resp_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL flush_idle_ignored: got %b expected 000",
                     {busIf.bus_req, busIf.exc_valid, busIf.resp_valid});
        end
        nextCycle();
        drive(1'b0, MEM_WORD, 32'h0000_0008, 32'h0);
        nextCycle();
        busIf.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            busIf.flush   = (i == 1);
            busIf.bus_ack = (i == 3);
            #1;
            checks++;
            if ({busIf.bus_req, busIf.stall, busIf.resp_valid} !== 3'b110) begin
                failures++;
                $display("[TB] FAIL flush_bus_cycle%0d: got %b expected 110", i,
                         {busIf.bus_req, busIf.stall, busIf.resp_valid});
            end
            nextCycle();
        end
        idleInputs();
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.stall, busIf.bus_req} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL flush_discard: got %b expected 000",
                     {busIf.resp_valid, busIf.stall, busIf.bus_req});
        end
        nextCycle();
        #1;
        checks++;
        if (busIf.resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_no_late_resp: got %b expected 0", busIf.resp_valid);
        end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        drive(1'b0, MEM_HALF_S, 32'h0000_0002, 32'h0);
        nextCycle();
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h8001_0000;
        #1;
        checks++;
        if (busIf.bus_be !== 4'b1100) begin
            failures++;
            $display("[TB] FAIL b2b_half_be: got %b expected 1100", busIf.bus_be);
        end
        nextCycle();
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        drive(1'b0, MEM_BYTE_U, 32'h0000_0001, 32'h0);
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.stall, busIf.resp_rdata} !== {2'b10, 32'hFFFF_8001}) begin
            failures++;
            $display("[TB] FAIL b2b_resp: got valid=%b stall=%b rdata=%h expected 1 0 ffff8001",
                     busIf.resp_valid, busIf.stall, busIf.resp_rdata);
        end
        nextCycle();
        #1;
        checks++;
        if ({busIf.stall, busIf.bus_req, busIf.resp_valid} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept: got %b expected 100",
                     {busIf.stall, busIf.bus_req, busIf.resp_valid});
        end
        nextCycle();
        busIf.req_valid = 1'b0;
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h0000_AB00;
        #1;
        checks++;
        if ({busIf.bus_req, busIf.bus_be} !== {1'b1, 4'b0010}) begin
            failures++;
            $display("[TB] FAIL b2b_byte_bus: got req=%b be=%b expected req=1 be=0010",
                     busIf.bus_req, busIf.bus_be);
        end
        nextCycle();
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.resp_rdata} !== {1'b1, 32'h0000_00AB}) begin
            failures++;
            $display("[TB] FAIL b2b_byte_resp: got valid=%b rdata=%h expected 1 000000ab",
                     busIf.resp_valid, busIf.resp_rdata);
        end
        nextCycle();
    endtask

    task automatic test_timeout();
        int lowCycles;
        drive(1'b0, MEM_WORD, 32'h0000_0020, 32'h0);
        nextCycle();
        busIf.req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({busIf.bus_req, busIf.stall} !== 2'b11) begin
                failures++;
                $display("[TB] FAIL timeout_wait%0d: got %b expected 11", i,
                         {busIf.bus_req, busIf.stall});
            end
            nextCycle();
        end
        #1;
        checks++;
        if ({busIf.bus_req, busIf.stall, busIf.exc_valid, busIf.exc_code} !== {3'b001, 5'd7}) begin
            failures++;
            $display("[TB] FAIL timeout_dbe: got req=%b stall=%b exc=%b code=%0d expected 0 0 1 7",
                     busIf.bus_req, busIf.stall, busIf.exc_valid, busIf.exc_code);
        end
        busIf.bus_ack = 1'b1;
        nextCycle();
        busIf.bus_ack = 1'b0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.exc_valid, busIf.bus_req} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL timeout_late_ack: got %b expected 000",
                     {busIf.resp_valid, busIf.exc_valid, busIf.bus_req});
        end
        nextCycle();
`else
        lowCycles = 0;
        repeat (100) begin
            #1;
            if (!(busIf.stall === 1'b1 && busIf.bus_req === 1'b1)) begin
                lowCycles++;
            end
            nextCycle();
        end
        checks++;
        if (lowCycles !== 0) begin
            failures++;
            $display("[TB] FAIL hang_stall: got %0d cycles without stall expected 0", lowCycles);
        end
        busIf.bus_ack   = 1'b1;
        busIf.bus_rdata = 32'h1122_3344;
        nextCycle();
        busIf.bus_ack   = 1'b0;
        busIf.bus_rdata = 32'h0;
        #1;
        checks++;
        if ({busIf.resp_valid, busIf.exc_valid, busIf.resp_rdata} !== {2'b10, 32'h1122_3344}) begin
            failures++;
            $display("[TB] FAIL hang_release: got valid=%b exc=%b rdata=%h expected 1 0 11223344",
                     busIf.resp_valid, busIf.exc_valid, busIf.resp_rdata);
        end
        nextCycle();
`endif
    endtask

    task automatic test_reset_mid_bus();
        drive(1'b0, MEM_WORD, 32'h0000_0010, 32'h0);
        nextCycle();
        #1;
        checks++;
        if (busIf.bus_req !== 1'b1) begin
            failures++;
            $display("[TB] FAIL midreset_pre: got %b expected 1", busIf.bus_req);
        end
        nextCycle();
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({busIf.bus_req, busIf.stall, busIf.resp_valid, busIf.bus_addr} !== {3'b000, RstAddr}) begin
            failures++;
            $display("[TB] FAIL midreset_drop: got req=%b stall=%b resp=%b addr=%h expected 0 0 0 %h",
                     busIf.bus_req, busIf.stall, busIf.resp_valid, busIf.bus_addr, RstAddr);
        end
        idleInputs();
        #1 reset = 1'b1;
        nextCycle();
        #1;
        checks++;
        if ({busIf.bus_req, busIf.resp_valid, busIf.exc_valid} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midreset_after: got %b expected 000",
                     {busIf.bus_req, busIf.resp_valid, busIf.exc_valid});
        end
        nextCycle();
    endtask

    initial begin
        $display("[TB] starting m_mem_access bench");
        test_reset();
        test_word_load();
        test_byte_signed_load();
        test_half_store();
        test_misaligned();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_reset_mid_bus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m_mem_access.md
Name: m_mem_access

Overview:
- Memory-access stage unit between the M pipeline register and the W pipeline register of the 5-stage MIPS core.
- Takes one load/store per instruction from the M stage and drives a word-wide req/ack data bus toward DM or the bridge/timers.
- Stalls the pipeline until the bus answers, extends load data, and flags address exceptions.
- resp_rdata feeds the W register's memory-read input directly.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles allowed before a bus error is raised (used only with MEM_TIMEOUT_EN).
RESET_ADDR, 32'h0000_3000, value driven on bus_addr while idle/reset.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  1  M stage holds a memory instruction
req_we  in  1  1 = store, 0 = load
req_type  in  3  0 word, 1 half-unsigned, 2 half-signed, 3 byte-unsigned, 4 byte-signed (stores use 0/1/3)
req_addr  in  32  byte address
req_wdata  in  32  store data (low bits significant)
flush  in  1  CP0 exception/eret flush of M stage
stall  out  1  freeze PC..M registers
resp_valid  out  1  one-cycle pulse: access complete, M may advance
resp_rdata  out  32  extended load data (0 for stores)
exc_valid  out  1  one-cycle exception pulse
exc_code  out  5  4 AdEL, 5 AdES, 7 DBE
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  write strobe
bus_addr  out  32  word-aligned address
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  transaction complete (sampled at posedge)
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset values (immediate, asynchronous):
  - State IDLE.
  - All outputs 0, except bus_addr = RESET_ADDR.
  - A reset mid-BUS drops bus_req at once.
- FSM states: IDLE, BUS, RESP, EXC.
- IDLE, cycle T, accept when req_valid && !flush:
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to EXC. stall=0. No bus activity.
  - Otherwise: register the access and go to BUS. stall=1 combinationally in T.
  - flush=1 in IDLE: ignore the request, no stall.
- BUS:
  - bus_req=1; bus_we/addr/be/wdata held stable; stall=1.
  - Posedge with bus_ack=1: latch the extended rdata and go to RESP.
  - bus_ack may arrive in the first BUS cycle, so minimum accept-to-resp_valid latency is 2 cycles.
- RESP: resp_valid=1, stall=0 for one cycle, then IDLE. A new request in the RESP cycle is not accepted; it is taken in the next IDLE cycle.
- EXC:
  - exc_valid=1 for one cycle.
  - exc_code = 4 for a load, 5 for a store.
  - Then IDLE.
- Flush during BUS:
  - The transaction cannot be withdrawn; bus_req stays asserted until ack.
  - The result is discarded: resp_valid is not pulsed, and RESP is skipped (straight to IDLE).
  - stall stays 1 until ack.
- Byte enables:
  - word: 1111
  - half: addr[1] ? 1100 : 0011
  - byte: 0001 << addr[1:0]
- bus_wdata: byte replicated ×4; half replicated ×2.
- Load extract selects the lane by addr[1:0]:
  - signed types sign-extend; unsigned types zero-extend.
  - word passes through unchanged.
- bus_addr = {req_addr[31:2], 2'b00}.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: an 8+ bit counter clears on BUS entry and increments each BUS cycle without ack.
  - Counter reaches TIMEOUT_CYCLES: drop bus_req, go to EXC with exc_code=7 (DBE), even if flushed.
  - A late ack is ignored.
- Undefined: no counter; BUS waits indefinitely; code 7 never produced.

Decomposition:
- Shared package mem_pkg:
  - req_type encodings
  - exc_code constants (EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7)
  - FSM state encoding
  - RESET_ADDR default
- Sub-module mem_load_ext: combinational lane select and extension (addr[1:0], type, word -> 32-bit result), reused by the W-stage bypass.

Test Plan:
- Word load 0x0000_0004, bus_ack 3 cycles after bus_req, bus_rdata=0xDEADBEEF:
  - stall high from accept through the ack cycle.
  - resp_valid pulses once with resp_rdata=0xDEADBEEF.
  - bus_be=1111 throughout BUS.
- Byte-signed load addr 0x0000_0003, ack in first BUS cycle, rdata=0x80FF_1234 -> resp_rdata=0xFFFF_FF80, two-cycle latency.
- Half store addr 0x0000_0006, wdata=0x0000_ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCD_ABCD, resp_rdata=0.
- Word load addr 0x0000_0002 -> no bus_req, stall=0, exc_valid pulse with exc_code=4.
- Half store addr 0x0000_0001 -> no bus_req, stall=0, exc_valid pulse with exc_code=5.
- flush asserted in the second BUS cycle, ack 2 cycles later -> bus_req held until ack, no resp_valid, then IDLE.
- reset driven low mid-BUS -> bus_req=0 and stall=0 immediately.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, never ack -> bus_req drops after 4 cycles, exc_code=7.
  - Without the macro, stall stays high for 100 cycles.
